// File: rtl/keypad_pkg.sv
// Shared constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;

  // Scanner FSM encoding
  localparam logic [1:0] SCAN    = 2'd0;
  localparam logic [1:0] CONFIRM = 2'd1;
  localparam logic [1:0] PRESSED = 2'd2;

  localparam logic [3:0] COL_IDLE = 4'b1111;

  // Active-low column drive pattern for column index idx
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    col_drive = COL_IDLE & ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous active-low keypad rows.
module keypad_row_sync
  import keypad_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_n_async,
  output logic [NUM_ROWS-1:0] row_n_sync
);

  logic [NUM_ROWS-1:0] meta_q;
  logic [NUM_ROWS-1:0] sync_q;

  // Idle (all rows high) after reset so no phantom key is seen
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= row_n_async;
      sync_q <= meta_q;
    end
  end

  assign row_n_sync = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column rotation, per-frame first-hit capture, debounce FSM.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES    = 12000,
  parameter int unsigned DEBOUNCE_SCANS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic                key_active,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_release
);

  localparam int unsigned DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_SCANS - 1);

  logic [NUM_ROWS-1:0] row_sync;

  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [3:0]    col_n_q, col_n_d;
  logic          frame_hit_q, frame_hit_d;
  logic [3:0]    frame_code_q, frame_code_d;
  logic [1:0]    state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rel_cnt_q, rel_cnt_d;
  logic          key_active_q, key_active_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_release_q, key_release_d;

  logic          sample, frame_end, col_hit, hit_now, accept;
  logic [1:0]    col_row;
  logic [3:0]    code_now, acc_code;

  keypad_row_sync u_row_sync (
    .clk         (clk),
    .reset       (reset),
    .row_n_async (row_n),
    .row_n_sync  (row_sync)
  );

  // Lowest-numbered active row in the currently driven column
  always_comb begin
    col_row = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!row_sync[i]) col_row = 2'(i);
    end
  end

  assign sample    = (dwell_q == DWELL_LAST);
  assign frame_end = sample && (col_idx_q == 2'd3);
  assign col_hit   = sample && (row_sync != '1);
  // Frame result including the col 3 sample taken on the frame-end cycle itself
  assign hit_now   = frame_hit_q | col_hit;
  assign code_now  = frame_hit_q ? frame_code_q : {col_row, col_idx_q};

  // Next state: dwell/column rotation, frame capture and debounce FSM
  always_comb begin
    dwell_d       = dwell_q + DW'(1);
    col_idx_d     = col_idx_q;
    col_n_d       = col_n_q;
    frame_hit_d   = frame_hit_q;
    frame_code_d  = frame_code_q;
    state_d       = state_q;
    cand_d        = cand_q;
    cnt_d         = cnt_q;
    rel_cnt_d     = rel_cnt_q;
    key_active_d  = key_active_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_release_d = 1'b0;
    accept        = 1'b0;
    acc_code      = cand_q;

    if (sample) begin
      dwell_d   = '0;
      col_idx_d = col_idx_q + 2'd1;
      col_n_d   = col_drive(col_idx_q + 2'd1);
      if (frame_end) begin
        frame_hit_d  = 1'b0;
        frame_code_d = 4'd0;
      end else if (!frame_hit_q && col_hit) begin
        frame_hit_d  = 1'b1;
        frame_code_d = code_now;
      end
    end

    if (frame_end) begin
      case (state_q)
        SCAN: begin
          if (hit_now) begin
            cand_d = code_now;
            cnt_d  = CW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              accept   = 1'b1;
              acc_code = code_now;
            end else begin
              state_d = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (!hit_now) begin
            state_d = SCAN;
            cnt_d   = '0;
          end else if (code_now != cand_q) begin
            cand_d = code_now;
            cnt_d  = CW'(1);
          end else if (cnt_q == CNT_LAST) begin
            accept   = 1'b1;
            acc_code = cand_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PRESSED: begin
          // A different key alone still counts toward release of the held one
          if (hit_now && (code_now == key_code_q)) begin
            rel_cnt_d = '0;
          end else if (rel_cnt_q == CNT_LAST) begin
            rel_cnt_d     = '0;
            key_active_d  = 1'b0;
            key_release_d = 1'b1;
            state_d       = SCAN;
          end else begin
            rel_cnt_d = rel_cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      endcase

      if (accept) begin
        key_code_d   = acc_code;
        key_active_d = 1'b1;
        key_valid_d  = 1'b1;
        state_d      = PRESSED;
        cnt_d        = '0;
        rel_cnt_d    = '0;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_q       <= '0;
      col_idx_q     <= 2'd0;
      col_n_q       <= col_drive(2'd0);
      frame_hit_q   <= 1'b0;
      frame_code_q  <= 4'd0;
      state_q       <= SCAN;
      cand_q        <= 4'd0;
      cnt_q         <= '0;
      rel_cnt_q     <= '0;
      key_active_q  <= 1'b0;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      dwell_q       <= dwell_d;
      col_idx_q     <= col_idx_d;
      col_n_q       <= col_n_d;
      frame_hit_q   <= frame_hit_d;
      frame_code_q  <= frame_code_d;
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      rel_cnt_q     <= rel_cnt_d;
      key_active_q  <= key_active_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_release_q <= key_release_d;
    end
  end

  assign col_n       = col_n_q;
  assign key_active  = key_active_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_release = key_release_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: frame-level key model, event queue, negedge monitor.
module tb_keypad_scanner;

  localparam int SC    = 4;
  localparam int DS    = 3;
  localparam int FRAME = 4 * SC;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       key_active;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_release;
  logic [15:0] keys = '0;

  typedef struct {
    bit rel;
    int code;
    int edge_no;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  rst_at_edge = 1'b0;
  bit  armed = 1'b0;

  // Reference model state (frame granularity)
  int  fidx = 0;
  int  hist[$];
  bit  held = 1'b0;
  int  hcode = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_CYCLES    (SC),
    .DEBOUNCE_SCANS (DS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .row_n       (row_n),
    .col_n       (col_n),
    .key_active  (key_active),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_release (key_release)
  );

  // Keypad: a pressed key pulls its row low while its column is driven
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && (col_n[c] === 1'b0)) row_n[r] = 1'b0;
  end

  always @(posedge clk) begin
    rst_at_edge <= reset;
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, time %0t)", name, act, exp, cyc, $time);
    end
  endtask

  // First key in scan order: columns ascending, rows ascending within a column
  function automatic int frame_result(input logic [15:0] k);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (k[r*4+c]) return r * 4 + c;
    return -1;
  endfunction

  task automatic do_frame(input logic [15:0] k);
    int  res;
    bit  fire;
    ev_t e;
    keys = k;
    res  = frame_result(k);
    hist.push_back(res);
    fire = 1'b0;
    if (hist.size() >= DS) begin
      fire = 1'b1;
      for (int i = hist.size() - DS; i < hist.size(); i++) begin
        if (!held && (res < 0 || hist[i] != res)) fire = 1'b0;
        if (held && hist[i] == hcode) fire = 1'b0;
      end
    end
    if (fire) begin
      e.rel     = held;
      e.code    = held ? hcode : res;
      e.edge_no = FRAME * (fidx + 1);
      exp_q.push_back(e);
      if (!held) hcode = res;
      held = !held;
      hist.delete();
    end
    fidx++;
    repeat (FRAME) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    hist.delete();
    held = 1'b0;
    fidx = 0;
  endtask

  // Monitor: pops expected pulses and tracks the expected output levels
  initial begin : monitor
    bit         act;
    int         code;
    int         ci;
    logic [3:0] ec;
    ev_t        e;
    act  = 1'b0;
    code = 0;
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        armed = 1'b1;
        act   = 1'b0;
        code  = 0;
        chk("reset_key_valid", int'(key_valid), 0);
        chk("reset_key_release", int'(key_release), 0);
      end
      if (armed) begin
        ci     = (cyc / SC) % 4;
        ec     = 4'hF;
        ec[ci] = 1'b0;
        chk("col_n", int'(col_n), int'(ec));
        while (exp_q.size() > 0 && cyc > exp_q[0].edge_no) begin
          e = exp_q.pop_front();
          chk("missing_pulse_edge", cyc, e.edge_no);
        end
        if (key_valid && key_release) begin
          chk("both_pulses", 1, 0);
        end else if (key_valid || key_release) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse_release", int'(key_release), -1);
          end else begin
            e = exp_q.pop_front();
            chk("pulse_is_release", int'(key_release), int'(e.rel));
            chk("pulse_edge", cyc, e.edge_no);
            chk("pulse_key_code", int'(key_code), e.code);
            act  = !e.rel;
            code = e.code;
          end
        end
        chk("key_active", int'(key_active), int'(act));
        chk("key_code", int'(key_code), code);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [15:0] k;
    int          sel;
    keys = '0;
    do_reset(3);

    // Idle: rotation only, no pulses
    repeat (10) do_frame(16'h0000);

    // Hold key 9 (row2/col1), then release
    repeat (5) do_frame(16'h0001 << 9);
    repeat (4) do_frame(16'h0000);

    // Key 9 on alternate frames never debounces
    repeat (6) begin
      do_frame(16'h0001 << 9);
      do_frame(16'h0000);
    end

    // Keys 2 (row0/col2) and 13 (row3/col1) together; col1 scans first so 13 wins
    repeat (5) do_frame((16'h0001 << 2) | (16'h0001 << 13));
    // Drop 13, keep 2: release of 13, then fresh press of 2
    repeat (8) do_frame(16'h0001 << 2);
    repeat (5) do_frame(16'h0000);

    // Reset while PRESSED, key still held afterwards
    repeat (5) do_frame(16'h0001 << 9);
    do_reset(1);
    repeat (5) do_frame(16'h0001 << 9);
    repeat (4) do_frame(16'h0000);

    // Random key sets with persistence so presses actually debounce
    k = '0;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      if (sel >= 5 && sel < 8) k = 16'h0001 << $urandom_range(0, 15);
      else if (sel == 8)       k = (16'h0001 << $urandom_range(0, 15)) |
                                   (16'h0001 << $urandom_range(0, 15));
      else if (sel == 9)       k = '0;
      do_frame(k);
    end
    repeat (5) do_frame(16'h0000);

    repeat (2) @(negedge clk);
    chk("events_outstanding", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
